ascon_perm_core: RTL and testbench
==================================

Name: ascon_perm_core

Overview:
Parametrised Ascon permutation engine p^nr with a per-operation round count (nr = 0..12, covering p^12, p^8 and p^6) and configurable unrolling of UNROLL rounds per clock.
- Loads a 320-bit state through a start/ready handshake, iterates constant-addition, S-box and linear-diffusion rounds, then presents the result with an out_valid/out_ready handshake.
- Sits between the mode controller (absorb/squeeze FSM) and the state register file.

Parameters:
UNROLL, 1, rounds computed per clock; legal values 1, 2, 3, 4 (elaboration error otherwise)
MAX_ROUNDS, 12, upper bound for rounds_i; fixed at 12 for the constant schedule

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
start_i  input  1  request to load state_i and run rounds_i rounds
ready_o  output  1  core idle; start accepted when start_i && ready_o at clk rising edge
rounds_i  input  4  number of rounds nr; sampled with start; values >12 clamped to 12
state_i  input  320  input state {x0,x1,x2,x3,x4}, x0 in [319:256], x4 in [63:0]
state_o  output  320  permuted state, same packing, valid while out_valid_o
out_valid_o  output  1  result available
out_ready_i  input  1  consumer accepts result when out_valid_o && out_ready_i at edge
busy_o  output  1  high in RUN state

Behaviour:
- Reset values: ready_o=1, out_valid_o=0, busy_o=0, state_o=0, internal remaining-round counter=0, round index=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: ready_o=1. On start accept: latch state_i into the state register, latch nr=min(rounds_i,12), set k=12-nr.
    - nr=0: go to DONE (state unchanged).
    - else: go to RUN.
  - RUN: each edge applies r=min(UNROLL, remaining) rounds in sequence. Then k+=r, remaining-=r. When remaining reaches 0, go to DONE.
  - DONE: out_valid_o=1, state_o=state register. On out_ready_i, go to IDLE.
    - ready_o=0 in DONE: back-to-back start is accepted on the cycle after hand-off, not the same one.
- Latency: out_valid_o rises ceil(nr/UNROLL) cycles after the start-accept edge, or 1 cycle when nr=0 (first cycle after accept).
  - UNROLL=1, nr=12 -> 12 cycles.
  - UNROLL=4, nr=6 -> 2 cycles; second cycle applies 2 rounds, unused unrolled stages bypassed.
- Round with constant index k (0..11):
  - c = {4'(15-k), 4'(k)}; k=0 -> 0xf0, k=11 -> 0x4b. x2[7:0] ^= c.
  - S-box: 5-bit Ascon S-box per bit column i, input {x0[i],x1[i],x2[i],x3[i],x4[i]} MSB-first, e.g. 0x00->0x04, 0x04->0x1a, 0x1f->0x17.
  - Linear layer (ror = rotate right):
    - x0^=ror19^ror28
    - x1^=ror61^ror39
    - x2^=ror1^ror6
    - x3^=ror10^ror17
    - x4^=ror7^ror41
- start_i while not ready_o: ignored, no effect.
- state_o holds stable in DONE regardless of out_ready_i deassertion; inputs outside accept edge are don't-care.
- Async reset mid-RUN or mid-DONE: immediately back to IDLE with reset values; no partial result is ever flagged valid.
- Stages are pure combinational between state registers; no multicycle paths.

Test Plan:
- UNROLL=1: state=0, rounds_i=1, start -> out_valid_o one cycle later; x2=0x53FFFFFFFFFFFF90, x3=0x12E580000000004B, x4=0, x0/x1 match golden model.
- UNROLL=1: state x0..x4 = 00001000808c0001, f23494a4b1f09f72, 1120821ab7ef5039, 0288f6cd3f44a4c2, 122103181031374d; rounds_i=12 -> out_valid_o exactly 12 cycles after accept; state_o equals golden p^12; busy_o high 12 cycles.
- Same state with rounds_i=8 and rounds_i=6 -> constants start at 0xb4 / 0x96; result matches golden p^8/p^6; latency 8/6 cycles.
- UNROLL=4, rounds_i=6 -> valid after 2 cycles, result identical to the UNROLL=1 run; rounds_i=0 -> valid after 1 cycle, state_o==state_i; rounds_i=15 -> treated as 12.
- Back-pressure: hold out_ready_i=0 for 5 cycles in DONE -> out_valid_o and state_o stable, ready_o=0, start_i pulses ignored; raise out_ready_i -> IDLE next cycle.
- Assert rst_n low at RUN cycle 5 -> ready_o=1, out_valid_o=0, state_o=0 immediately; a new start then completes normally with the correct result.

Source files
------------

// File: rtl/ascon_perm_core.sv
// Ascon permutation p^nr engine: loads a 320-bit state, runs nr (0..12) rounds
// at UNROLL rounds per clock, and hands the result out over a valid/ready handshake.
module ascon_perm_core #(
  parameter int UNROLL     = 1,
  parameter int MAX_ROUNDS = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  output logic         ready_o,
  input  logic [3:0]   rounds_i,
  input  logic [319:0] state_i,
  output logic [319:0] state_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic         busy_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  localparam logic [3:0] MAX_NR = 4'(MAX_ROUNDS);

  if (UNROLL < 1 || UNROLL > 4) begin : g_bad_unroll
    $error("ascon_perm_core: UNROLL must be 1, 2, 3 or 4");
  end

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // One full round with constant index k: constant addition, bitsliced S-box, linear layer.
  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] k);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    x2[7:0] = x2[7:0] ^ {4'd15 - k, k};
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  fsm_e         r_fsm;
  fsm_e         w_fsm_next;
  logic [319:0] r_state;
  logic [3:0]   r_remaining;
  logic [3:0]   r_k;
  logic [3:0]   w_nr;
  logic [3:0]   w_step;
  logic [319:0] w_stage [0:UNROLL];

  assign w_nr   = (rounds_i > MAX_NR) ? MAX_NR : rounds_i;
  assign w_step = (r_remaining < 4'(UNROLL)) ? r_remaining : 4'(UNROLL);

  // Unrolled chain; stages beyond the remaining round count pass the state through.
  assign w_stage[0] = r_state;
  for (genvar j = 0; j < UNROLL; j++) begin : g_stage
    logic [3:0] w_k;
    assign w_k          = r_k + 4'(j);
    assign w_stage[j+1] = (4'(j) < r_remaining) ? ascon_round(w_stage[j], w_k) : w_stage[j];
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_fsm_next = r_fsm;
    case (r_fsm)
      IDLE:    if (start_i) w_fsm_next = (w_nr == 4'd0) ? DONE : RUN;
      RUN:     if (r_remaining == w_step) w_fsm_next = DONE;
      DONE:    if (out_ready_i) w_fsm_next = IDLE;
      default: w_fsm_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= IDLE;
    end else begin
      r_fsm <= w_fsm_next;
    end
  end

  // NOTE: the wide state register is reset so state_o never shows stale data after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= '0;
      r_remaining <= '0;
      r_k         <= '0;
    end else if (r_fsm == IDLE && start_i) begin
      r_state     <= state_i;
      r_remaining <= w_nr;
      r_k         <= MAX_NR - w_nr;
    end else if (r_fsm == RUN) begin
      r_state     <= w_stage[UNROLL];
      r_remaining <= r_remaining - w_step;
      r_k         <= r_k + w_step;
    end
  end

  assign ready_o     = (r_fsm == IDLE);
  assign busy_o      = (r_fsm == RUN);
  assign out_valid_o = (r_fsm == DONE);
  assign state_o     = r_state;

endmodule

// File: tb/tb_ascon_perm_core.sv
// Directed bench for ascon_perm_core: one UNROLL=1 and one UNROLL=4 instance,
// checked against hand-derived constants and a table-driven S-box reference.
module tb_ascon_perm_core;

  logic         clk;
  logic         rst_n;
  logic         start     [2];
  logic         ready     [2];
  logic [3:0]   rounds    [2];
  logic [319:0] st_in     [2];
  logic [319:0] st_out    [2];
  logic         valid     [2];
  logic         out_ready [2];
  logic         busy      [2];

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  localparam logic [319:0] VEC = {
    64'h00001000808c0001, 64'hf23494a4b1f09f72, 64'h1120821ab7ef5039,
    64'h0288f6cd3f44a4c2, 64'h122103181031374d
  };

  ascon_perm_core #(.UNROLL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start[0]), .ready_o(ready[0]),
    .rounds_i(rounds[0]), .state_i(st_in[0]), .state_o(st_out[0]),
    .out_valid_o(valid[0]), .out_ready_i(out_ready[0]), .busy_o(busy[0])
  );

  ascon_perm_core #(.UNROLL(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_i(start[1]), .ready_o(ready[1]),
    .rounds_i(rounds[1]), .state_i(st_in[1]), .state_o(st_out[1]),
    .out_valid_o(valid[1]), .out_ready_i(out_ready[1]), .busy_o(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] rr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Reference permutation: S-box applied column by column through the lookup table.
  function automatic logic [319:0] model_perm(input logic [319:0] s, input logic [3:0] nr_raw);
    logic [63:0] x [5];
    logic [4:0]  col, sb;
    int          nr;
    nr = (nr_raw > 4'd12) ? 12 : int'(nr_raw);
    for (int w = 0; w < 5; w++) x[w] = s[319 - 64*w -: 64];
    for (int r = 12 - nr; r < 12; r++) begin
      x[2][7:0] = x[2][7:0] ^ 8'((15 - r) * 16 + r);
      for (int i = 0; i < 64; i++) begin
        col = {x[0][i], x[1][i], x[2][i], x[3][i], x[4][i]};
        sb  = SBOX[col];
        x[0][i] = sb[4]; x[1][i] = sb[3]; x[2][i] = sb[2]; x[3][i] = sb[1]; x[4][i] = sb[0];
      end
      x[0] = x[0] ^ rr(x[0], 19) ^ rr(x[0], 28);
      x[1] = x[1] ^ rr(x[1], 61) ^ rr(x[1], 39);
      x[2] = x[2] ^ rr(x[2], 1)  ^ rr(x[2], 6);
      x[3] = x[3] ^ rr(x[3], 10) ^ rr(x[3], 17);
      x[4] = x[4] ^ rr(x[4], 7)  ^ rr(x[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  // Starts an operation on instance d; lat counts edges after the accept edge until out_valid_o.
  task automatic run_op(input int d, input logic [319:0] st, input logic [3:0] nr,
                        output logic [319:0] res, output int lat, output int busy_n, output bit to);
    @(negedge clk);
    start[d] = 1'b1; st_in[d] = st; rounds[d] = nr;
    @(posedge clk); #1;
    start[d] = 1'b0; st_in[d] = '0; rounds[d] = '0;
    lat = 0; busy_n = 0; to = 1'b0;
    while (!valid[d] && !to) begin
      if (busy[d]) busy_n++;
      if (lat >= 50) to = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    res = st_out[d];
  endtask

  task automatic consume(input int d);
    @(negedge clk);
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
  endtask

  logic [319:0] res_p12_u1, res_p6_u1;

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #5;
    for (int d = 0; d < 2; d++) begin
      checks++; if (ready[d] !== 1'b1) begin errors++; $display("FAIL reset_ready[%0d]: got %b want 1", d, ready[d]); end
      checks++; if (valid[d] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d]: got %b want 0", d, valid[d]); end
      checks++; if (busy[d] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", d, busy[d]); end
      checks++; if (st_out[d] !== 320'd0) begin errors++; $display("FAIL reset_state[%0d]: got %h want 0", d, st_out[d]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_one_round();
    logic [319:0] res; int lat, bn; bit to;
    run_op(0, 320'd0, 4'd1, res, lat, bn, to);
    checks++; if (to || lat !== 1) begin errors++; $display("FAIL one_round_latency: got %0d (timeout %0d) want 1", lat, to); end
    checks++; if (res[191:128] !== 64'h53FFFFFFFFFFFF90) begin errors++; $display("FAIL one_round_x2: got %h want 53ffffffffffff90", res[191:128]); end
    checks++; if (res[127:64] !== 64'h12E580000000004B) begin errors++; $display("FAIL one_round_x3: got %h want 12e580000000004b", res[127:64]); end
    checks++; if (res[63:0] !== 64'd0) begin errors++; $display("FAIL one_round_x4: got %h want 0", res[63:0]); end
    checks++; if (res !== model_perm(320'd0, 4'd1)) begin errors++; $display("FAIL one_round_state: got %h want %h", res, model_perm(320'd0, 4'd1)); end
    consume(0);
  endtask

  task automatic test_rounds_u1();
    logic [319:0] res; int lat, bn; bit to;
    logic [3:0] nrs [3] = '{4'd12, 4'd8, 4'd6};
    for (int i = 0; i < 3; i++) begin
      run_op(0, VEC, nrs[i], res, lat, bn, to);
      checks++; if (to || lat !== int'(nrs[i])) begin errors++; $display("FAIL u1_p%0d_latency: got %0d want %0d", nrs[i], lat, nrs[i]); end
      checks++; if (bn !== int'(nrs[i])) begin errors++; $display("FAIL u1_p%0d_busy_cycles: got %0d want %0d", nrs[i], bn, nrs[i]); end
      checks++; if (res !== model_perm(VEC, nrs[i])) begin errors++; $display("FAIL u1_p%0d_state: got %h want %h", nrs[i], res, model_perm(VEC, nrs[i])); end
      if (nrs[i] == 4'd12) res_p12_u1 = res;
      if (nrs[i] == 4'd6)  res_p6_u1  = res;
      consume(0);
      checks++; if (ready[0] !== 1'b1 || valid[0] !== 1'b0) begin errors++; $display("FAIL u1_p%0d_handoff: got ready=%b valid=%b want 1/0", nrs[i], ready[0], valid[0]); end
    end
  endtask

  task automatic test_unroll4();
    logic [319:0] res; int lat, bn; bit to;
    run_op(1, VEC, 4'd6, res, lat, bn, to);
    checks++; if (to || lat !== 2) begin errors++; $display("FAIL u4_p6_latency: got %0d want 2", lat); end
    checks++; if (res !== res_p6_u1) begin errors++; $display("FAIL u4_p6_vs_u1: got %h want %h", res, res_p6_u1); end
    consume(1);
    run_op(1, VEC, 4'd0, res, lat, bn, to);
    checks++; if (to || lat !== 0) begin errors++; $display("FAIL u4_p0_latency: got %0d edges after accept want 0", lat); end
    checks++; if (res !== VEC) begin errors++; $display("FAIL u4_p0_state: got %h want %h", res, VEC); end
    consume(1);
    run_op(1, VEC, 4'd15, res, lat, bn, to);
    checks++; if (to || lat !== 3) begin errors++; $display("FAIL u4_clamp_latency: got %0d want 3", lat); end
    checks++; if (res !== res_p12_u1 || res !== model_perm(VEC, 4'd12)) begin errors++; $display("FAIL u4_clamp_state: got %h want %h", res, model_perm(VEC, 4'd12)); end
    consume(1);
    run_op(0, ~VEC, 4'd15, res, lat, bn, to);
    checks++; if (to || lat !== 12) begin errors++; $display("FAIL u1_clamp_latency: got %0d want 12", lat); end
    consume(0);
  endtask

  task automatic test_backpressure();
    logic [319:0] res, want; int lat, bn; bit to;
    want = model_perm(VEC ^ 320'h5a5a, 4'd3);
    run_op(0, VEC ^ 320'h5a5a, 4'd3, res, lat, bn, to);
    checks++; if (to || res !== want) begin errors++; $display("FAIL bp_result: got %h want %h", res, want); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      start[0] = c[0]; st_in[0] = ~VEC; rounds[0] = 4'd1;
      @(posedge clk); #1;
      checks++; if (valid[0] !== 1'b1 || ready[0] !== 1'b0 || st_out[0] !== want) begin
        errors++; $display("FAIL bp_hold_%0d: got valid=%b ready=%b state=%h want 1/0/%h", c, valid[0], ready[0], st_out[0], want);
      end
    end
    start[0] = 1'b0;
    consume(0);
    checks++; if (ready[0] !== 1'b1 || valid[0] !== 1'b0 || busy[0] !== 1'b0) begin errors++; $display("FAIL bp_release: got ready=%b valid=%b busy=%b want 1/0/0", ready[0], valid[0], busy[0]); end
    run_op(0, VEC, 4'd2, res, lat, bn, to);
    checks++; if (to || lat !== 2 || res !== model_perm(VEC, 4'd2)) begin errors++; $display("FAIL back_to_back: got lat=%0d state=%h want 2/%h", lat, res, model_perm(VEC, 4'd2)); end
    consume(0);
  endtask

  task automatic test_reset_mid_run();
    logic [319:0] res; int lat, bn; bit to;
    @(negedge clk);
    start[0] = 1'b1; st_in[0] = VEC; rounds[0] = 4'd12;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL mid_run_busy: got %b want 1", busy[0]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ready[0] !== 1'b1 || valid[0] !== 1'b0 || busy[0] !== 1'b0) begin errors++; $display("FAIL mid_run_reset_flags: got ready=%b valid=%b busy=%b want 1/0/0", ready[0], valid[0], busy[0]); end
    checks++; if (st_out[0] !== 320'd0) begin errors++; $display("FAIL mid_run_reset_state: got %h want 0", st_out[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, VEC, 4'd12, res, lat, bn, to);
    checks++; if (to || lat !== 12 || res !== res_p12_u1) begin errors++; $display("FAIL after_reset_p12: got lat=%0d state=%h want 12/%h", lat, res, res_p12_u1); end
    consume(0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; rounds[d] = '0; st_in[d] = '0; out_ready[d] = 1'b0;
    end
    test_reset();
    test_one_round();
    test_rounds_u1();
    test_unroll4();
    test_backpressure();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
